// File: rtl/serdes_pkg.sv
// serdes_pkg: shared definitions for the serializer/deserializer link.
//   OPCODEW_DEF / ADDRW_DEF : default field widths
//   state_e                 : frame FSM states (IDLE, RECV)
//   framew()                : total frame width from the two field widths
package serdes_pkg;

  localparam int OPCODEW_DEF = 2;
  localparam int ADDRW_DEF   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  function automatic int framew(input int opcodew, input int addrw);
    return opcodew + addrw;
  endfunction

endpackage

// File: rtl/deserializer_sync_edge.sv
// sync_edge: 2-flop synchronizer with a registered previous value for edge
// detection.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input line
//   sync     : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// RST_VAL is the idle level of the line; all flops reset to it.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [2:0] primed_q, primed_d;

  // Edges are only reported once prev_q holds a real sample rather than the
  // reset value; otherwise a line already away from its idle level at reset
  // release would produce a spurious edge.
  always_comb begin
    meta_d   = d;
    sync_d   = meta_q;
    prev_d   = sync_q;
    primed_d = {primed_q[1:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= RST_VAL;
      sync_q   <= RST_VAL;
      prev_q   <= RST_VAL;
      primed_q <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
    end
  end

  assign sync = sync_q;
  assign rise = primed_q[2] & sync_q & ~prev_q;
  assign fall = primed_q[2] & ~sync_q & prev_q;

endmodule

// File: rtl/deserializer.sv
// deserializer: SPI responder-side frame receiver (mode 0, MSB first).
//   clk, rst          : system clock, async active-high reset
//   n_cs, spi_clk,
//   mosi              : asynchronous SPI lines
//   valid_out         : a decoded frame is held on opcode/addr
//   opcode, addr      : frame fields (registered)
//   ready_in          : consumer accepts the frame
//   err               : one-cycle pulse per malformed or overrun frame
module deserializer
  import serdes_pkg::*;
#(
  parameter int OPCODEW = OPCODEW_DEF,
  parameter int ADDRW   = ADDRW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               n_cs,
  input  logic               spi_clk,
  input  logic               mosi,
  output logic               valid_out,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   addr,
  input  logic               ready_in,
  output logic               err
);

  localparam int FRAMEW = framew(OPCODEW, ADDRW);
  localparam int CNTW   = $clog2(FRAMEW + 2);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FRAMEW);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(FRAMEW + 1);

  logic cs_sync, cs_rise, cs_fall;
  logic spi_sync, spi_rise, spi_fall;

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (n_cs),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_spi_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_clk),
    .sync (spi_sync),
    .rise (spi_rise),
    .fall (spi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{cs_sync, spi_sync, spi_fall};

  // mosi gets the same two-flop delay as the edge detectors' sync output, so
  // its level is aligned with spi_rise.
  logic mosi_meta_q, mosi_meta_d;
  logic mosi_sync_q, mosi_sync_d;

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [FRAMEW-1:0]  shift_q, shift_d;
  logic               valid_q, valid_d;
  logic [OPCODEW-1:0] opcode_q, opcode_d;
  logic [ADDRW-1:0]   addr_q, addr_d;
  logic               err_q, err_d;

  always_comb begin
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    err_d       = 1'b0;

    if (valid_q && ready_in) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        if (spi_rise) begin
          shift_d = {shift_q[FRAMEW-2:0], mosi_sync_q};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q != CNT_FULL) begin
            err_d = 1'b1;
          end else if (!valid_q || ready_in) begin
            opcode_d = shift_q[FRAMEW-1:ADDRW];
            addr_d   = shift_q[ADDRW-1:0];
            valid_d  = 1'b1;
          end else begin
            // Slot still held: keep the old frame, flag the overrun.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
    end
  end

  assign valid_out = valid_q;
  assign opcode    = opcode_q;
  assign addr      = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       n_cs = 1'b1;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic       ready_in = 1'b1;
  logic       valid_out;
  logic [1:0] opcode;
  logic [7:0] addr;
  logic       err;

  deserializer #(.OPCODEW(2), .ADDRW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .n_cs      (n_cs),
    .spi_clk   (spi_clk),
    .mosi      (mosi),
    .valid_out (valid_out),
    .opcode    (opcode),
    .addr      (addr),
    .ready_in  (ready_in),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int err_seen = 0;
  int xfer_seen = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    n_cs = 1'b0;
    cyc(4);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      cyc(2);
      spi_clk = 1'b1;
      cyc(4);
      spi_clk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic end_frame();
    cyc(2);
    n_cs = 1'b1;
  endtask

  task automatic full_frame(input logic [15:0] v, input int n);
    start_frame();
    send_bits(v, n);
    end_frame();
    cyc(8);
  endtask

  // Monitor: samples 1 time unit after the falling edge, after inputs settle.
  logic err_prev = 1'b0;
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (err) begin
          err_seen++;
          check("err_width", {31'd0, err_prev}, 32'd0);
        end
        if (valid_out && ready_in) begin
          xfer_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("xfer_frame", {22'd0, opcode, addr}, {22'd0, e});
          end
        end
      end
      err_prev = err;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic drain();
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int e0, x0;

    // Reset while idle
    cyc(3);
    check("rst_idle_out", {20'd0, valid_out, err, opcode, addr}, 32'd0);
    rst = 1'b0;
    cyc(1);
    check("rst_release_out", {20'd0, valid_out, err, opcode, addr}, 32'd0);
    cyc(4);

    // Nominal frame with latency check
    exp_q.push_back({2'b10, 8'hA5});
    e0 = err_seen;
    start_frame();
    send_bits({6'd0, 2'b10, 8'hA5}, 10);
    end_frame();
    cyc(2);
    check("nom_valid_k1", {31'd0, valid_out}, 32'd0);
    cyc(1);
    check("nom_valid_k2", {31'd0, valid_out}, 32'd1);
    check("nom_data_k2", {22'd0, opcode, addr}, {22'd0, 2'b10, 8'hA5});
    check("nom_err", {31'd0, err}, 32'd0);
    cyc(1);
    check("nom_valid_clr", {31'd0, valid_out}, 32'd0);
    cyc(6);
    drain();
    check("nom_err_cnt", err_seen - e0, 0);

    // Short frame (9 bits)
    e0 = err_seen; x0 = xfer_seen;
    full_frame(16'h0155, 9);
    check("short_err", err_seen - e0, 1);
    check("short_novalid", xfer_seen - x0, 0);

    // Long frame (11 bits)
    e0 = err_seen; x0 = xfer_seen;
    full_frame(16'h02AA, 11);
    check("long_err", err_seen - e0, 1);
    check("long_novalid", xfer_seen - x0, 0);

    // Backpressure
    ready_in = 1'b0;
    e0 = err_seen;
    exp_q.push_back({2'b01, 8'h3C});
    full_frame({6'd0, 2'b01, 8'h3C}, 10);
    check("bp_hold1", {21'd0, valid_out, opcode, addr}, {21'd0, 1'b1, 2'b01, 8'h3C});
    full_frame({6'd0, 2'b11, 8'hFF}, 10);
    check("bp_hold2", {21'd0, valid_out, opcode, addr}, {21'd0, 1'b1, 2'b01, 8'h3C});
    check("bp_overrun_err", err_seen - e0, 1);
    x0 = xfer_seen;
    ready_in = 1'b1;
    cyc(1);
    check("bp_valid_clr", {31'd0, valid_out}, 32'd0);
    check("bp_one_xfer", xfer_seen - x0, 1);
    drain();

    // Reset mid-frame
    e0 = err_seen; x0 = xfer_seen;
    start_frame();
    send_bits(16'h0015, 5);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_out", {20'd0, valid_out, err, opcode, addr}, 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("rst_mid_release", {20'd0, valid_out, err, opcode, addr}, 32'd0);
    send_bits(16'h000A, 5);
    end_frame();
    cyc(10);
    check("rst_mid_noerr", err_seen - e0, 0);
    check("rst_mid_novalid", xfer_seen - x0, 0);

    // Next full frame delivered normally
    exp_q.push_back({2'b00, 8'h01});
    full_frame({6'd0, 2'b00, 8'h01}, 10);
    drain();
    check("post_rst_xfer", xfer_seen - x0, 1);
    check("post_rst_noerr", err_seen - e0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
